// File: rtl/mproc_pkg.sv
// rtl/mproc_pkg.sv - shared widths and loader state encoding for the processor subsystem
package mproc_pkg;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 16;
    localparam int RAM_DEPTH = 128;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CNT  = 3'd1;
    localparam logic [2:0] ST_HI   = 3'd2;
    localparam logic [2:0] ST_LO   = 3'd3;
    localparam logic [2:0] ST_CHK  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_CNT  = ST_CNT,
        S_HI   = ST_HI,
        S_LO   = ST_LO,
        S_CHK  = ST_CHK,
        S_DONE = ST_DONE,
        S_ERR  = ST_ERR
    } ldr_state_e;

endpackage

// File: rtl/mproc_loader.sv
// rtl/mproc_loader.sv - framed byte-stream program loader for the 128x16 program RAM
module mproc_loader
    import mproc_pkg::*;
#(
    parameter int ADDR_W = mproc_pkg::ADDR_W,
    parameter int DATA_W = mproc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    ldr_state_e        state_q, state_d;
    logic [7:0]        remaining_q, remaining_d;
    logic [7:0]        cks_q, cks_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;

    assign accept = in_valid && in_ready_q;

    // State and registered outputs; reset drops any half-assembled word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            cks_q       <= '0;
            hi_q        <= '0;
            word_idx_q  <= '0;
            in_ready_q  <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cks_q       <= cks_d;
            hi_q        <= hi_d;
            word_idx_q  <= word_idx_d;
            in_ready_q  <= in_ready_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Frame parser: count, hi/lo word pairs, then checksum compare
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cks_d       = cks_q;
        hi_d        = hi_q;
        word_idx_d  = word_idx_q;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_d       = err_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_CNT;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    cpu_hold_d = 1'b1;
                    word_idx_d = '0;
                end
            end
            S_CNT: begin
                if (accept) begin
                    remaining_d = (in_byte == 8'd0) ? 8'd128 : in_byte;
                    cks_d       = in_byte;
                    state_d     = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = in_byte;
                    cks_d   = cks_q ^ in_byte;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = word_idx_q;
                    mem_din_d   = {hi_q, in_byte};
                    cks_d       = cks_q ^ in_byte;
                    remaining_d = remaining_q - 8'd1;
                    // Hold the index on the final word so a full-depth load never wraps
                    if (remaining_d != 8'd0) begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = S_HI;
                    end else begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    if (in_byte == cks_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_CNT) || (state_d == S_HI) ||
                     (state_d == S_LO)  || (state_d == S_CHK);
    end

    assign in_ready = in_ready_q;
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mproc_loader.sv
// tb/tb_mproc_loader.sv - scoreboard bench for mproc_loader with randomized frames and stalls
module tb_mproc_loader;
    import mproc_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_byte;
    logic        in_ready, mem_wr, cpu_hold, done, err;
    logic [6:0]  mem_addr;
    logic [15:0] mem_din;

    int total = 0;
    int bad   = 0;

    logic [7:0]  frame[$];
    logic [6:0]  exp_addr[$];
    logic [15:0] exp_data[$];
    logic [6:0]  mon_a;
    logic [15:0] mon_d;

    mproc_loader #(.ADDR_W(7), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next predicted write
    always @(negedge clk) begin
        if (!reset && mem_wr) begin
            if (exp_addr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h@%0h want none", mem_din, mem_addr);
            end else begin
                mon_a = exp_addr.pop_front();
                mon_d = exp_data.pop_front();
                chk("wr_addr", {25'd0, mem_addr}, {25'd0, mon_a});
                chk("wr_data", {16'd0, mem_din}, {16'd0, mon_d});
            end
        end
    end

    // Reference model: derive writes and verdict from the frame bytes
    task automatic predict(output bit ok);
        int n;
        logic [7:0] c;
        n = (frame[0] == 8'd0) ? 128 : int'(frame[0]);
        c = 8'd0;
        for (int i = 0; i <= 2 * n; i++) c ^= frame[i];
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(7'(w));
            exp_data.push_back({frame[1 + 2 * w], frame[2 + 2 * w]});
        end
        ok = (frame[2 * n + 1] == c);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_done", {31'd0, done}, 32'd0);
        chk("start_err", {31'd0, err}, 32'd0);
        chk("start_hold", {31'd0, cpu_hold}, 32'd1);
        chk("start_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_byte  = b;
        start    = st;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: got in_ready=0 want 1");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_frame(input int gap, input int start_at);
        bit ok;
        predict(ok);
        do_start();
        foreach (frame[i]) send_byte(frame[i], gap, (i == start_at));
        @(negedge clk);
        chk("pending_writes", exp_addr.size(), 32'd0);
        chk("done", {31'd0, done}, {31'd0, ok});
        chk("err", {31'd0, err}, {31'd0, !ok});
        chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, !ok});
        chk("ready_idle", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic basic_frame(input logic [7:0] ck);
        frame = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, ck};
    endtask

    initial begin
        bit ok;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_addr", {25'd0, mem_addr}, 32'd0);
        chk("rst_din", {16'd0, mem_din}, 32'd0);
        @(posedge clk); #1;

        // Basic load, then bad checksum, then recovery
        basic_frame(8'h42); run_frame(0, -1);
        basic_frame(8'h00); run_frame(0, -1);
        basic_frame(8'h42); run_frame(0, -1);

        // Full-depth load with word value addr*0x0101
        frame = '{8'h00};
        for (int a = 0; a < RAM_DEPTH; a++) begin
            frame.push_back(8'(a));
            frame.push_back(8'(a));
        end
        frame.push_back(8'h00);
        run_frame(0, -1);
        chk("full_last_addr", {25'd0, mem_addr}, 32'h7F);
        chk("full_last_data", {16'd0, mem_din}, 32'h7F7F);

        // Random stalls on the basic frame
        for (int r = 0; r < 3; r++) begin
            basic_frame(8'h42); run_frame(5, -1);
        end

        // Reset one cycle after the high byte of word 1 is accepted
        do_start();
        exp_addr.push_back(7'd0);
        exp_data.push_back(16'h1234);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        send_byte(8'hAB, 0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_wr", {31'd0, mem_wr}, 32'd0);
        chk("midrst_addr", {25'd0, mem_addr}, 32'd0);
        chk("midrst_din", {16'd0, mem_din}, 32'd0);
        chk("midrst_pending", exp_addr.size(), 32'd0);
        repeat (2) begin @(negedge clk); chk("midrst_no_wr", {31'd0, mem_wr}, 32'd0); end
        @(posedge clk); #1;
        basic_frame(8'h42); run_frame(0, -1);

        // Start pulsed while the loader waits for a high byte
        basic_frame(8'h42); run_frame(0, 1);
        basic_frame(8'h42); run_frame(3, 3);

        // Random frames, random gaps, random checksum corruption
        for (int r = 0; r < 6; r++) begin
            int n;
            logic [7:0] c;
            n = $urandom_range(1, 8);
            frame = '{8'(n)};
            c = 8'(n);
            for (int i = 0; i < 2 * n; i++) begin
                frame.push_back(8'($urandom_range(0, 255)));
                c ^= frame[frame.size() - 1];
            end
            if ($urandom_range(0, 1) == 1) c ^= 8'(1 << $urandom_range(0, 7));
            frame.push_back(c);
            run_frame(3, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
